rising_intr_ctrl: RTL and testbench
===================================

Name: rising_intr_ctrl

Overview:
- Slow-clock-domain interrupt controller placed after the per-bit rising-edge interrupt synchronizers.
- Detects rising edges on the synchronized lines and latches them as pending.
- Applies a software enable mask and selects one source by round-robin.
- Presents that source to a single CPU-side target through a claim/complete handshake, so each edge is serviced exactly once.

Parameters:
- INTR_WIDTH, 8, number of interrupt sources (1..32).
- ID_WIDTH, 3, width of irq_id; must satisfy 2**ID_WIDTH >= INTR_WIDTH.

Ports:
- clk  input  1  controller clock (the slow clock).
- rst  input  1  asynchronous active-high reset.
- intr_in  input  INTR_WIDTH  synchronized interrupt levels; a 0->1 transition is an event.
- cfg_en_wr  input  1  one-cycle strobe that loads the enable mask.
- cfg_en_wdata  input  INTR_WIDTH  new enable mask.
- intr_en  output  INTR_WIDTH  current enable mask.
- intr_pending  output  INTR_WIDTH  current pending bits.
- irq  output  1  interrupt request to the target.
- irq_id  output  ID_WIDTH  index of the presented or active source.
- claim  input  1  one-cycle pulse: target takes the presented interrupt.
- complete  input  1  one-cycle pulse: target finished the active interrupt.
- busy  output  1  high while a claimed interrupt awaits complete.

Behaviour:
- Reset values (asynchronous on rst):
  - state=IDLE; irq=0; irq_id=0; busy=0.
  - intr_pending=0; intr_en=0; intr_d=0.
  - last_served=INTR_WIDTH-1, so the first search starts at index 0.
- Edge detect:
  - intr_d is intr_in registered every cycle.
  - rise = intr_in & ~intr_d (combinational).
  - A line already high in the first cycle after reset counts as a rise.
- Pending:
  - pending[i] is set when rise[i]=1, independent of intr_en.
  - pending[i] is cleared only by a claim accepted while irq_id==i.
  - If rise[i] and the clearing claim occur in the same cycle, pending[i] ends set; the new edge wins.
- Enable mask:
  - On cfg_en_wr, intr_en <= cfg_en_wdata, visible the next cycle.
  - Masking never clears pending.
- eligible = intr_pending & intr_en.
- Arbitration (round-robin): the winner is the first set eligible bit scanning upward from (last_served+1) mod INTR_WIDTH, wrapping around.
- FSM, IDLE:
  - If eligible != 0: irq_id <= winner, irq <= 1, go to ASSERT.
  - Otherwise stay in IDLE.
  - claim and complete are ignored.
- FSM, ASSERT:
  - irq=1; irq_id is held stable.
  - On claim: clear pending[irq_id] (subject to the same-cycle rule above), irq <= 0, busy <= 1, go to ACTIVE.
  - If intr_en[irq_id] drops (and no claim that cycle): irq <= 0, go to IDLE; pending is kept.
  - If claim and the enable drop occur in the same cycle, the claim wins.
  - complete is ignored.
- FSM, ACTIVE:
  - irq=0; busy=1; irq_id holds the active source.
  - On complete: last_served <= irq_id, busy <= 0, go to IDLE.
  - claim is ignored.
  - A new rise on the active source re-sets its pending bit; it is re-presented after complete, subject to round-robin order.
- Latency:
  - A rise seen by the controller in cycle N sets pending, visible in cycle N+1.
  - If the controller is in IDLE and the source is enabled, irq=1 is visible in cycle N+2.
  - After complete in cycle M, the next eligible source asserts irq in cycle M+2 (IDLE is occupied in M+1).
- Outputs are registered; irq has no combinational path from the inputs.
- Only one interrupt is outstanding at a time; the controller has no nesting.

Test Plan:
- Reset, then enable 0xFF; raise intr_in[3] -> pending=0x08 one cycle after the controller sees the rise, irq=1 with irq_id=3 two cycles after it; claim -> irq=0, busy=1, pending=0x00; complete -> busy=0, state IDLE.
- With enable 0x00, pulse intr_in[5] -> pending=0x20 and irq stays 0; write enable 0x20 -> irq=1 with irq_id=5 within 2 cycles.
- Raise lines 1, 4 and 6 simultaneously with all enabled -> service order is id 1, 4, 6. Then, with last_served=6, pend lines 2 and 7 -> next served is 7, then 2 (wrap check).
- In ASSERT with irq_id=2, clear intr_en[2] -> irq falls the next cycle and pending[2] stays 1; re-enable -> irq_id=2 is presented again.
- In ASSERT with irq_id=0: drive claim together with a fresh rise on intr_in[0] -> pending[0]=1 after the claim. Then complete -> id 0 is re-presented. Also: claim in IDLE and complete in ASSERT have no effect.
- Assert rst mid-ACTIVE with pending=0x0C -> irq, busy, pending and intr_en go to 0 immediately, state is IDLE, and no irq after release while enable=0.

Source files
------------

// File: rtl/rising_intr_ctrl.sv
// Rising-edge interrupt controller: latches 0->1 events as pending, masks them,
// picks one by round-robin and serves it through a claim/complete handshake.
module rising_intr_ctrl #(
  parameter int INTR_WIDTH = 8,
  parameter int ID_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INTR_WIDTH-1:0] intr_in,
  input  logic                  cfg_en_wr,
  input  logic [INTR_WIDTH-1:0] cfg_en_wdata,
  output logic [INTR_WIDTH-1:0] intr_en,
  output logic [INTR_WIDTH-1:0] intr_pending,
  output logic                  irq,
  output logic [ID_WIDTH-1:0]   irq_id,
  input  logic                  claim,
  input  logic                  complete,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [INTR_WIDTH-1:0] intr_d_r;
  logic [INTR_WIDTH-1:0] pending_r;
  logic [INTR_WIDTH-1:0] en_r;
  logic                  irq_r;
  logic [ID_WIDTH-1:0]   irq_id_r;
  logic                  busy_r;
  logic [ID_WIDTH-1:0]   last_served_r;

  logic [INTR_WIDTH-1:0] rise_s;
  logic [INTR_WIDTH-1:0] eligible_s;
  logic [INTR_WIDTH-1:0] pend_clr_s;
  logic [INTR_WIDTH-1:0] pending_nx_s;
  logic [ID_WIDTH-1:0]   winner_s;
  int                    scan_idx_s;
  logic                  irq_nx_s;
  logic [ID_WIDTH-1:0]   irq_id_nx_s;
  logic                  busy_nx_s;
  logic [ID_WIDTH-1:0]   last_served_nx_s;

  assign rise_s       = intr_in & ~intr_d_r;
  assign eligible_s   = pending_r & en_r;
  assign intr_en      = en_r;
  assign intr_pending = pending_r;
  assign irq          = irq_r;
  assign irq_id       = irq_id_r;
  assign busy         = busy_r;

  // Round-robin search: scanning from the far end down means the nearest
  // eligible source after last_served is the final (winning) assignment.
  always_comb begin
    winner_s   = '0;
    scan_idx_s = 0;
    for (int k = INTR_WIDTH; k >= 1; k--) begin
      scan_idx_s = (int'(last_served_r) + k) % INTR_WIDTH;
      winner_s   = eligible_s[scan_idx_s] ? ID_WIDTH'(scan_idx_s) : winner_s;
    end
  end

  // Next-state and next-output logic for the presentation handshake.
  always_comb begin
    next_state_s     = state_r;
    irq_nx_s         = irq_r;
    irq_id_nx_s      = irq_id_r;
    busy_nx_s        = busy_r;
    last_served_nx_s = last_served_r;
    pend_clr_s       = '0;
    case (state_r)
      IDLE: begin
        busy_nx_s = 1'b0;
        if (|eligible_s) begin
          irq_id_nx_s  = winner_s;
          irq_nx_s     = 1'b1;
          next_state_s = ASSERT;
        end else begin
          irq_nx_s = 1'b0;
        end
      end
      ASSERT: begin
        if (claim) begin
          pend_clr_s[irq_id_r] = 1'b1;
          irq_nx_s             = 1'b0;
          busy_nx_s            = 1'b1;
          next_state_s         = ACTIVE;
        end else if (!en_r[irq_id_r]) begin
          irq_nx_s     = 1'b0;
          next_state_s = IDLE;
        end else begin
          irq_nx_s = 1'b1;
        end
      end
      ACTIVE: begin
        irq_nx_s = 1'b0;
        if (complete) begin
          last_served_nx_s = irq_id_r;
          busy_nx_s        = 1'b0;
          next_state_s     = IDLE;
        end else begin
          busy_nx_s = 1'b1;
        end
      end
      default: begin
        next_state_s = IDLE;
        irq_nx_s     = 1'b0;
        busy_nx_s    = 1'b0;
      end
    endcase
    // A fresh edge on the line being claimed survives the clear.
    pending_nx_s = (pending_r & ~pend_clr_s) | rise_s;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered outputs, pending bits, enable mask and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intr_d_r      <= '0;
      pending_r     <= '0;
      en_r          <= '0;
      irq_r         <= 1'b0;
      irq_id_r      <= '0;
      busy_r        <= 1'b0;
      last_served_r <= ID_WIDTH'(INTR_WIDTH - 1);
    end else begin
      intr_d_r      <= intr_in;
      pending_r     <= pending_nx_s;
      irq_r         <= irq_nx_s;
      irq_id_r      <= irq_id_nx_s;
      busy_r        <= busy_nx_s;
      last_served_r <= last_served_nx_s;
      if (cfg_en_wr) begin
        en_r <= cfg_en_wdata;
      end else begin
        en_r <= en_r;
      end
    end
  end

endmodule

// File: tb/tb_rising_intr_ctrl.sv
// Table-driven bench for rising_intr_ctrl: each row drives one cycle of inputs
// and lists the register outputs expected right after that clock edge.
module tb_rising_intr_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] intr_in;
  logic       cfg_en_wr;
  logic [7:0] cfg_en_wdata;
  logic [7:0] intr_en;
  logic [7:0] intr_pending;
  logic       irq;
  logic [2:0] irq_id;
  logic       claim;
  logic       complete;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic [7:0] intr;
    logic       wr;
    logic [7:0] wdata;
    logic       clm;
    logic       cmp;
    logic       e_irq;
    logic [2:0] e_id;
    logic       e_busy;
    logic [7:0] e_pend;
    logic [7:0] e_en;
  } vec_t;

  vec_t tbl[$];

  rising_intr_ctrl #(.INTR_WIDTH(8), .ID_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .intr_in(intr_in), .cfg_en_wr(cfg_en_wr),
    .cfg_en_wdata(cfg_en_wdata), .intr_en(intr_en), .intr_pending(intr_pending),
    .irq(irq), .irq_id(irq_id), .claim(claim), .complete(complete), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic r, input logic [7:0] i, input logic w,
                             input logic [7:0] wd, input logic c, input logic d,
                             input logic eirq, input logic [2:0] eid,
                             input logic ebusy, input logic [7:0] epend,
                             input logic [7:0] een);
    vec_t t;
    t.rst = r; t.intr = i; t.wr = w; t.wdata = wd; t.clm = c; t.cmp = d;
    t.e_irq = eirq; t.e_id = eid; t.e_busy = ebusy; t.e_pend = epend; t.e_en = een;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic e_irq, input logic [2:0] e_id,
                           input logic e_busy, input logic [7:0] e_pend,
                           input logic [7:0] e_en);
    check("irq", row, {31'd0, irq}, {31'd0, e_irq});
    check("irq_id", row, {29'd0, irq_id}, {29'd0, e_id});
    check("busy", row, {31'd0, busy}, {31'd0, e_busy});
    check("pending", row, {24'd0, intr_pending}, {24'd0, e_pend});
    check("intr_en", row, {24'd0, intr_en}, {24'd0, e_en});
  endtask

  initial begin
    //                rst intr   wr wdata  clm cmp irq id    busy pend   en
    // basic service of line 3
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF));
    tbl.push_back(v(1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 8'hFF));
    tbl.push_back(v(1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 8'hFF));
    tbl.push_back(v(1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, 8'hFF));
    tbl.push_back(v(1'b0, 8'h08, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00, 8'hFF));
    tbl.push_back(v(1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'hFF));
    // masked pend of line 5, then enable
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h20, 8'h00));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h20, 8'h00));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h20, 8'h20));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 8'h20, 8'h20));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 8'h00, 8'h20));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 8'h00, 8'h20));
    // reset, then lines 1/4/6 together served in order
    tbl.push_back(v(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF));
    tbl.push_back(v(1'b0, 8'h52, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h52, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h52, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 8'h50, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h50, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h50, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 8'h40, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 8'h40, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 8'h40, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd6, 1'b1, 8'h00, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 8'h00, 8'hFF));
    // wrap: lines 2 and 7 after last_served=6
    tbl.push_back(v(1'b0, 8'h84, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 8'h84, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 8'h84, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 8'h04, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 8'h04, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h04, 8'hFF));
    // mask line 2 while presented, then re-enable
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 8'hFB, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h04, 8'hFB));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h04, 8'hFB));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h04, 8'hFB));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h04, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h04, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'h00, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 8'h00, 8'hFF));
    // line 0: complete ignored in ASSERT, claim races a fresh edge
    tbl.push_back(v(1'b0, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 8'h01, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h01, 8'hFF));
    tbl.push_back(v(1'b0, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h01, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h01, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h01, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h01, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'hFF));
    // reach ACTIVE on line 2 with pending=0x0C
    tbl.push_back(v(1'b0, 8'h0C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h0C, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h0C, 8'hFF));
    tbl.push_back(v(1'b0, 8'h04, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 8'h0C, 8'hFF));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 8'h0C, 8'hFF));

    rst = 1'b1; intr_in = 8'h00; cfg_en_wr = 1'b0; cfg_en_wdata = 8'h00;
    claim = 1'b0; complete = 1'b0;
    tick();
    tick();
    check_all(-1, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; intr_in = tbl[i].intr; cfg_en_wr = tbl[i].wr;
      cfg_en_wdata = tbl[i].wdata; claim = tbl[i].clm; complete = tbl[i].cmp;
      tick();
      check_all(i, tbl[i].e_irq, tbl[i].e_id, tbl[i].e_busy, tbl[i].e_pend, tbl[i].e_en);
    end
    rst = 1'b0; intr_in = 8'h00; cfg_en_wr = 1'b0; claim = 1'b0; complete = 1'b0;

    // Mid-cycle reset from ACTIVE must clear outputs without a clock edge.
    #2;
    intr_in = 8'h0C;
    rst = 1'b1;
    #1;
    check_all(100, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    rst = 1'b0;
    // Lines held high across reset register as rises, but stay masked.
    tick();
    check_all(101, 1'b0, 3'd0, 1'b0, 8'h0C, 8'h00);
    for (int j = 0; j < 3; j++) begin
      tick();
      check_all(102 + j, 1'b0, 3'd0, 1'b0, 8'h0C, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
